// File: rtl/seq_restoring_divider_if.sv
// rtl/seq_restoring_divider_if.sv - start/busy/done handshake and operand/result bundle for the divider
//
// Purpose: groups the request, status and result signals of seq_restoring_divider.
// Ports (signals):
//   start       requester -> divider  request, sampled only while ready=1
//   dividend    requester -> divider  unsigned dividend, DIVIDEND_W bits
//   divisor     requester -> divider  unsigned divisor, DIVISOR_W bits
//   ready       divider -> requester  start is accepted this cycle if high
//   busy        divider -> requester  division in progress
//   done        divider -> requester  one-cycle pulse, results valid from this cycle
//   quotient    divider -> requester  unsigned quotient, DIVIDEND_W bits
//   remainder   divider -> requester  unsigned remainder, DIVISOR_W bits
//   div_by_zero divider -> requester  last completed operation had divisor 0
interface seq_restoring_divider_if #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
);
  logic                  start;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  ready;
  logic                  busy;
  logic                  done;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  ready, busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output ready, busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_restoring_divider.sv
// rtl/seq_restoring_divider.sv - sequential restoring divider, one quotient bit per clock
//
// Purpose: unsigned DIVIDEND_W / DIVISOR_W division, MSB first, restoring algorithm.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    seq_restoring_divider_if.slave: start/dividend/divisor in,
//          ready/busy/done/quotient/remainder/div_by_zero out
module seq_restoring_divider #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4,
  parameter int CNT_W      = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  seq_restoring_divider_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  // Only the low DIVISOR_W bits of the partial remainder survive between
  // iterations (it is always < divisor); the shifted value is DIVISOR_W+1 bits.
  logic [DIVISOR_W-1:0]  pr_q, pr_d;
  // Dividend bits shift out at the MSB while quotient bits shift in at the LSB.
  logic [DIVIDEND_W-1:0] sr_q, sr_d;
  logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
  logic [DIVIDEND_W-1:0] quo_q, quo_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic                  dbz_q, dbz_d;

  logic [DIVISOR_W:0]    pr_shift;
  logic [DIVISOR_W:0]    trial;
  logic                  q_bit;
  logic                  accept;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      pr_q  <= '0;
      sr_q  <= '0;
      dvs_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dbz_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pr_q  <= pr_d;
      sr_q  <= sr_d;
      dvs_q <= dvs_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      dbz_q <= dbz_d;
    end
  end

  // One restoring step: the trial subtraction succeeds when it does not borrow.
  always_comb begin
    pr_shift = {pr_q, sr_q[DIVIDEND_W-1]};
    trial    = pr_shift - {1'b0, dvs_q};
    q_bit    = (pr_shift >= {1'b0, dvs_q});
  end

  // Next-state logic
  always_comb begin
    accept  = (state_q != S_RUN) && bus.start;
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = (bus.divisor == '0) ? S_DONE : S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    cnt_d = cnt_q;
    pr_d  = pr_q;
    sr_d  = sr_q;
    dvs_d = dvs_q;
    quo_d = quo_q;
    rem_d = rem_q;
    dbz_d = dbz_q;
    if (accept) begin
      dvs_d = bus.divisor;
      pr_d  = '0;
      sr_d  = bus.dividend;
      cnt_d = CNT_W'(DIVIDEND_W - 1);
      if (bus.divisor == '0) begin
        // Divide by zero bypasses RUN and reports a saturated quotient.
        quo_d = '1;
        rem_d = '0;
        dbz_d = 1'b1;
      end
    end else if (state_q == S_RUN) begin
      pr_d  = DIVISOR_W'(q_bit ? trial : pr_shift);
      sr_d  = {sr_q[DIVIDEND_W-2:0], q_bit};
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == '0) begin
        quo_d = sr_d;
        rem_d = pr_d;
        dbz_d = 1'b0;
      end
    end
  end

  // Outputs are functions of registered state only.
  always_comb begin
    bus.ready       = (state_q != S_RUN);
    bus.busy        = (state_q == S_RUN);
    bus.done        = (state_q == S_DONE);
    bus.quotient    = quo_q;
    bus.remainder   = rem_q;
    bus.div_by_zero = dbz_q;
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb/tb_seq_restoring_divider.sv - scoreboard bench for seq_restoring_divider with randomized stimulus
module tb_seq_restoring_divider;

  localparam int DIVIDEND_W = 8;
  localparam int DIVISOR_W  = 4;

  typedef struct {
    int q;
    int r;
    int dbz;
    int cyc;
    int busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  int   busy_run = 0;
  int   last_q = 0;
  int   last_r = 0;
  int   last_dbz = 0;
  exp_t exp_q[$];

  seq_restoring_divider_if #(.DIVIDEND_W(DIVIDEND_W), .DIVISOR_W(DIVISOR_W)) bus ();

  seq_restoring_divider #(.DIVIDEND_W(DIVIDEND_W), .DIVISOR_W(DIVISOR_W), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    compared++;
    if (act != expv) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference model: plain unsigned arithmetic.
  function automatic exp_t model(input int a, input int b, input int accept_cyc);
    exp_t e;
    if (b == 0) begin
      e.q = (1 << DIVIDEND_W) - 1;
      e.r = 0;
      e.dbz = 1;
      e.cyc = accept_cyc;
      e.busy = 0;
    end else begin
      e.q = a / b;
      e.r = a % b;
      e.dbz = 0;
      e.cyc = accept_cyc + DIVIDEND_W;
      e.busy = DIVIDEND_W;
    end
    return e;
  endfunction

  // Monitor: pops the scoreboard on every done pulse; between pulses the
  // result outputs must hold the last completed result.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busy_run = 0;
      last_q = 0;
      last_r = 0;
      last_dbz = 0;
    end else begin
      if (bus.busy) busy_run++;
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("quotient", int'(bus.quotient), e.q);
          chk("remainder", int'(bus.remainder), e.r);
          chk("div_by_zero", int'(bus.div_by_zero), e.dbz);
          chk("done_cycle", cyc, e.cyc);
          chk("busy_cycles", busy_run, e.busy);
          last_q = e.q;
          last_r = e.r;
          last_dbz = e.dbz;
        end
        busy_run = 0;
      end else begin
        chk("hold_quotient", int'(bus.quotient), last_q);
        chk("hold_remainder", int'(bus.remainder), last_r);
        chk("hold_div_by_zero", int'(bus.div_by_zero), last_dbz);
      end
    end
  end

  // Waits for ready, presents one request for one cycle (or holds start high
  // with scrambled operand pins until ready returns when hold=1).
  task automatic issue(input int a, input int b, input bit hold, input int gap);
    int guard;
    repeat (gap) @(negedge clk);
    guard = 0;
    while (!bus.ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.ready) begin
      chk("ready_timeout", 0, 1);
      return;
    end
    bus.start    = 1'b1;
    bus.dividend = DIVIDEND_W'(a);
    bus.divisor  = DIVISOR_W'(b);
    exp_q.push_back(model(a, b, cyc + 1));
    @(negedge clk);
    if (hold) begin
      guard = 0;
      while (!bus.ready && guard < 50) begin
        bus.dividend = DIVIDEND_W'($urandom);
        bus.divisor  = DIVISOR_W'($urandom);
        @(negedge clk);
        guard++;
      end
    end
    bus.start    = 1'b0;
    bus.dividend = DIVIDEND_W'($urandom);
    bus.divisor  = DIVISOR_W'($urandom);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, int'(bus.ready), 1);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
    chk({tag, "_quotient"}, int'(bus.quotient), 0);
    chk({tag, "_remainder"}, int'(bus.remainder), 0);
    chk({tag, "_div_by_zero"}, int'(bus.div_by_zero), 0);
  endtask

  initial begin
    int guard;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;

    #3 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;

    issue(200, 7, 0, 1);
    issue(225, 15, 0, 0);
    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        issue(a * b, b, 0, 0);
      end
    end

    issue(255, 1, 0, 0);
    issue(5, 9, 0, 0);
    issue(0, 3, 0, 2);
    issue(254, 15, 0, 0);

    issue(100, 0, 0, 1);
    issue(100, 10, 0, 0);

    issue(200, 7, 1, 0);
    issue(90, 6, 1, 0);
    issue(200, 7, 0, 0);
    issue(60, 4, 0, 0);

    // Reset in the fourth RUN cycle of 200/7: outputs clear before any edge.
    issue(200, 7, 0, 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    exp_q.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    issue(77, 5, 0, 0);

    for (int i = 0; i < 300; i++) begin
      int a;
      int b;
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 15);
      issue(a, b, bit'($urandom_range(0, 3) == 0), $urandom_range(0, 2));
    end

    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
